// File: rtl/fifo_stream_reader_pkg.sv
// fifo_stream_reader_pkg: shared types for the FIFO-to-stream reader.
// Holds the controller state encoding and the buffer occupancy type.
package fifo_stream_reader_pkg;

  // RUN streams entries out; FLUSH drains and discards the FIFO.
  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Output buffer holds at most two entries, so occupancy fits in 2 bits.
  localparam int unsigned CNT_BITS = 2;
  typedef logic [CNT_BITS-1:0] cnt_t;

endpackage

// File: rtl/fifo_stream_reader_buf.sv
// fifo_stream_reader_buf: 2-entry in-order buffer with push, pop and clear.
// Slot 0 is always the head. The parent guarantees push only when count<2
// and pop only when count>0; clear overrides both.
module fifo_stream_reader_buf
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned p_entry_bits = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [p_entry_bits-1:0] push_data,
  input  logic                    pop,
  input  logic                    clear,
  output cnt_t                    count,
  output logic [p_entry_bits-1:0] head
);

  logic [p_entry_bits-1:0] slot_q [2];
  logic [p_entry_bits-1:0] slot_d [2];
  cnt_t                    count_q;
  cnt_t                    count_d;

  // Next slot contents and occupancy for push/pop/clear combinations.
  always_comb begin
    slot_d[0] = slot_q[0];
    slot_d[1] = slot_q[1];
    count_d   = count_q;
    if (clear) begin
      count_d = '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count_q == cnt_t'(0)) slot_d[0] = push_data;
          else                      slot_d[1] = push_data;
          count_d = count_q + cnt_t'(1);
        end
        2'b01: begin
          slot_d[0] = slot_q[1];
          count_d   = count_q - cnt_t'(1);
        end
        2'b11: begin
          // Occupancy unchanged; the new entry lands behind whatever remains.
          if (count_q == cnt_t'(1)) begin
            slot_d[0] = push_data;
          end else begin
            slot_d[0] = slot_q[1];
            slot_d[1] = push_data;
          end
        end
        default: ;
      endcase
    end
  end

  // Buffer storage and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_q[0] <= '0;
      slot_q[1] <= '0;
      count_q   <= '0;
    end else begin
      slot_q[0] <= slot_d[0];
      slot_q[1] <= slot_d[1];
      count_q   <= count_d;
    end
  end

  assign count = count_q;
  assign head  = slot_q[0];

endmodule

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: drains a pop/empty/rdata FIFO into a val/rdy stream
// through a 2-entry buffer, with a flush that discards everything queued.
// Optional macro FIFO_STREAM_READER_COUNT_EN adds a saturating sent_count port.
module fifo_stream_reader
  import fifo_stream_reader_pkg::*;
#(
  parameter int unsigned p_entry_bits = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    fifo_empty,
  output logic                    fifo_pop,
  input  logic [p_entry_bits-1:0] fifo_rdata,
  output logic                    ostream_val,
  input  logic                    ostream_rdy,
  output logic [p_entry_bits-1:0] ostream_msg,
  input  logic                    flush,
  output logic                    flush_done
`ifdef FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [31:0]             sent_count
`endif
);

  state_e state_q;
  state_e state_d;
  cnt_t   count;
  logic   send;
  logic   flush_go;
  logic   buf_push;

  // Pop decision uses only registered state/count, never ostream_rdy.
  always_comb begin
    fifo_pop = 1'b0;
    if (!rst) begin
      if (state_q == RUN) fifo_pop = !fifo_empty && (count != cnt_t'(2));
      else                fifo_pop = !fifo_empty;
    end
  end

  assign ostream_val = (count != cnt_t'(0)) && (state_q == RUN);
  assign send        = ostream_val && ostream_rdy;
  assign flush_go    = (state_q == RUN) && flush;
  assign buf_push    = fifo_pop && (state_q == RUN);
  assign flush_done  = (state_q == FLUSH) && fifo_empty;

  fifo_stream_reader_buf #(
    .p_entry_bits(p_entry_bits)
  ) u_buf (
    .clk      (clk),
    .rst      (rst),
    .push     (buf_push),
    .push_data(fifo_rdata),
    .pop      (send),
    .clear    (flush_go),
    .count    (count),
    .head     (ostream_msg)
  );

  // Controller next state: enter FLUSH on request, leave once FIFO is empty.
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (flush) state_d = FLUSH;
      FLUSH:   if (fifo_empty) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Controller state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [31:0] sent_q;
  logic [31:0] sent_d;

  // Saturating count of completed output transfers, including one in a flush cycle.
  always_comb begin
    sent_d = sent_q;
    if (send && (sent_q != 32'hFFFF_FFFF)) sent_d = sent_q + 32'd1;
  end

  // Transfer counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sent_q <= '0;
    else     sent_q <= sent_d;
  end

  assign sent_count = sent_q;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: directed bench for fifo_stream_reader with a
// cycle-vector table plus hand-written reset, flush and random-rdy sequences.
// Build with FIFO_STREAM_READER_COUNT_EN defined to exercise sent_count.
module tb_fifo_stream_reader;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         fifo_empty;
  logic         fifo_pop;
  logic [W-1:0] fifo_rdata;
  logic         ostream_val;
  logic         ostream_rdy = 1'b0;
  logic [W-1:0] ostream_msg;
  logic         flush = 1'b0;
  logic         flush_done;
`ifdef FIFO_STREAM_READER_COUNT_EN
  logic [31:0]  sent_count;
`endif

  fifo_stream_reader #(.p_entry_bits(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_empty (fifo_empty),
    .fifo_pop   (fifo_pop),
    .fifo_rdata (fifo_rdata),
    .ostream_val(ostream_val),
    .ostream_rdy(ostream_rdy),
    .ostream_msg(ostream_msg),
    .flush      (flush),
    .flush_done (flush_done)
`ifdef FIFO_STREAM_READER_COUNT_EN
    ,
    .sent_count (sent_count)
`endif
  );

  always #5 clk = ~clk;

  // FIFO model: pushes from the stimulus, pops on edges where fifo_pop was seen.
  logic [W-1:0] mem [4096];
  int           wr_ptr = 0;
  int           rd_ptr = 0;
  bit           pop_seen = 1'b0;
  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[11:0]];

  // Output monitor, sampled mid-cycle.
  logic [W-1:0] rx [$];
  int n_send = 0, n_done = 0, n_bad_pop = 0;
  always @(negedge clk) begin
    pop_seen = fifo_pop;
    if (fifo_pop && fifo_empty) n_bad_pop++;
    if (ostream_val && ostream_rdy) begin
      rx.push_back(ostream_msg);
      n_send++;
    end
    if (flush_done) n_done++;
  end
  always @(posedge clk) if (pop_seen) rd_ptr <= rd_ptr + 1;

  int n_vec = 0, n_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] v);
    mem[wr_ptr[11:0]] = v;
    wr_ptr++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    int k = 0;
    ostream_rdy = 1'b1;
    while (!(fifo_empty && !ostream_val) && k < 200) begin
      tick();
      k++;
    end
    check(name, 64'(k < 200), 64'd1);
  endtask

  typedef struct {
    logic [W-1:0] base;
    int           n;
    bit           rdy;
    bit           fl;
    bit           val;
    logic [W-1:0] msg;
    bit           pop;
    bit           done;
  } vec_t;
  vec_t tbl [$];

  task automatic add(input logic [W-1:0] base, input int n, input bit rdy, input bit fl,
                     input bit val, input logic [W-1:0] msg, input bit pop, input bit done);
    vec_t v;
    v.base = base; v.n = n; v.rdy = rdy; v.fl = fl;
    v.val = val; v.msg = msg; v.pop = pop; v.done = done;
    tbl.push_back(v);
  endtask

  initial begin
    logic [W-1:0] exp_q [$];
    int base_rx, k, done_before;

    // Streaming: 8 entries, always ready.
    add(32'h11, 8, 1, 0, 0, 0, 1, 0);
    for (int c = 1; c <= 8; c++) add(0, 0, 1, 0, 1, 32'h10 + 32'(c), c < 8, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Backpressure: 4 entries, only 2 popped until ready rises.
    add(32'h21, 4, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 32'h21, 1, 0);
    add(0, 0, 0, 0, 1, 32'h21, 0, 0);
    add(0, 0, 0, 0, 1, 32'h21, 0, 0);
    add(0, 0, 1, 0, 1, 32'h21, 0, 0);
    add(0, 0, 1, 0, 1, 32'h22, 1, 0);
    add(0, 0, 1, 0, 1, 32'h23, 1, 0);
    add(0, 0, 1, 0, 1, 32'h24, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Flush with 2 buffered and 5 queued; second flush in FLUSH is ignored.
    add(32'h31, 7, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 1, 32'h31, 1, 0);
    add(0, 0, 0, 1, 1, 32'h31, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 1, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(32'hAB, 1, 1, 0, 0, 0, 1, 0);
    add(0, 0, 1, 0, 1, 32'hAB, 0, 0);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Flush with everything empty: one FLUSH cycle, done in that cycle.
    add(0, 0, 0, 1, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state.
    #3;
    check("reset_outputs", {ostream_val, ostream_msg, fifo_pop, flush_done}, 64'd0);
    tick();
    rst = 1'b0;
    #1;
    check("after_release", {ostream_val, fifo_pop, flush_done}, 64'd0);

`ifdef FIFO_STREAM_READER_COUNT_EN
    for (int i = 0; i < 37; i++) push(32'h500 + 32'(i));
    drain("cnt_drain_a");
    ostream_rdy = 1'b0;
    tick(); flush = 1'b1;
    tick(); flush = 1'b0;
    tick(); tick();
    for (int i = 0; i < 3; i++) push(32'h600 + 32'(i));
    drain("cnt_drain_b");
    tick(); ostream_rdy = 1'b0;
    check("sent_count_40", 64'(sent_count), 64'd40);
`endif

    // Table-driven cycle vectors.
    for (int i = 0; i < tbl.size(); i++) begin
      tick();
      for (int j = 0; j < tbl[i].n; j++) push(tbl[i].base + 32'(j));
      ostream_rdy = tbl[i].rdy;
      flush       = tbl[i].fl;
      #1;
      check($sformatf("vec%0d", i),
            {ostream_val, ostream_val ? ostream_msg : 32'h0, fifo_pop, flush_done},
            {tbl[i].val, tbl[i].val ? tbl[i].msg : 32'h0, tbl[i].pop, tbl[i].done});
    end
    flush = 1'b0;

    // Async reset mid-traffic, then reset in the middle of a flush.
    tick();
    for (int i = 0; i < 10; i++) push(32'h700 + 32'(i));
    ostream_rdy = 1'b1;
    tick(); tick();
    #1;
    rst = 1'b1;
    #1;
    check("rst_async", {ostream_val, ostream_msg, fifo_pop, flush_done}, 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_release", {ostream_val, fifo_pop, flush_done}, {1'b0, 1'b1, 1'b0});
    flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    check("flush_enter", {ostream_val, fifo_pop}, {1'b0, 1'b1});
    done_before = n_done;
    #1;
    rst = 1'b1;
    #1;
    check("rst_in_flush", {fifo_pop, flush_done}, 64'd0);
    tick();
    rst = 1'b0;
    drain("rst_drain");
    tick();
    check("no_done_after_rst", 64'(n_done), 64'(done_before));

    // Random ready over 1000 entries: order and content preserved.
    ostream_rdy = 1'b0;
    tick();
    base_rx = rx.size();
    for (int i = 0; i < 1000; i++) begin
      exp_q.push_back($urandom);
      push(exp_q[i]);
    end
    k = 0;
    while ((rx.size() - base_rx) < 1000 && k < 5000) begin
      tick();
      ostream_rdy = 1'($urandom_range(0, 1));
      k++;
    end
    ostream_rdy = 1'b0;
    check("random_count", 64'(rx.size() - base_rx), 64'd1000);
    for (int i = 0; i < 1000 && (base_rx + i) < rx.size(); i++)
      check($sformatf("random%0d", i), 64'(rx[base_rx + i]), 64'(exp_q[i]));

    tick();
    check("no_pop_when_empty", 64'(n_bad_pop), 64'd0);
`ifdef FIFO_STREAM_READER_COUNT_EN
    check("sent_count_total", 64'(sent_count), 64'(n_send));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
